// File: rtl/shift_reg_ctrl_pkg.sv
// shift_reg_ctrl_pkg: shared state type, state encodings and default sizing
// for the shift-register controller.
// Optional feature macro: SHIFT_REG_CTRL_PARITY_EN adds the PARITY state.
package shift_reg_ctrl_pkg;

  localparam int DEFAULT_SHIFT_WIDTH = 8;
  localparam int DEFAULT_GAP_CYCLES  = 1;

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_LOAD   = 3'd1;
  localparam logic [2:0] ST_SHIFT  = 3'd2;
  localparam logic [2:0] ST_PARITY = 3'd3;
  localparam logic [2:0] ST_GAP    = 3'd4;

  typedef enum logic [2:0] {
    IDLE   = ST_IDLE,
    LOAD   = ST_LOAD,
    SHIFT  = ST_SHIFT,
`ifdef SHIFT_REG_CTRL_PARITY_EN
    PARITY = ST_PARITY,
`endif
    GAP    = ST_GAP
  } state_t;

endpackage

// File: rtl/shift_reg_ctrl_if.sv
// shift_reg_ctrl_if: valid/ready word-input handshake of the controller.
// The master side offers words; the controller is the slave.
// Optional feature macro: SHIFT_REG_CTRL_PARITY_EN (no effect on this file).
interface shift_reg_ctrl_if #(
  parameter int SHIFT_WIDTH = shift_reg_ctrl_pkg::DEFAULT_SHIFT_WIDTH
);

  logic                   in_valid;
  logic                   in_ready;
  logic [SHIFT_WIDTH-1:0] in_data;

  modport master (
    output in_valid,
    output in_data,
    input  in_ready
  );

  modport slave (
    input  in_valid,
    input  in_data,
    output in_ready
  );

endinterface

// File: rtl/shift_bit_counter.sv
// shift_bit_counter: counts serialized bits 0..COUNT_MAX-1 and flags the last
// one. It saturates at the terminal count instead of wrapping.
// Optional feature macro: SHIFT_REG_CTRL_PARITY_EN (no effect on this file).
module shift_bit_counter #(
  parameter int COUNT_MAX = 8,
  localparam int CW = (COUNT_MAX > 1) ? $clog2(COUNT_MAX) : 1
) (
  input  logic clock,
  input  logic aclr_n,
  input  logic clear,
  input  logic inc,
  output logic tc
);

  localparam logic [CW-1:0] LAST = CW'(COUNT_MAX - 1);

  logic [CW-1:0] count_reg;

  // Clear has priority; increment stops at the last bit so no wrap occurs.
  always_ff @(posedge clock or negedge aclr_n) begin
    if (!aclr_n) begin
      count_reg <= '0;
    end else if (clear) begin
      count_reg <= '0;
    end else if (inc && !tc) begin
      count_reg <= count_reg + 1'b1;
    end
  end

  assign tc = (count_reg == LAST);

endmodule

// File: rtl/shift_reg_ctrl.sv
// shift_reg_ctrl: accepts parallel words and sequences an external
// left-shifting register so the word leaves MSB first on ser_out, followed
// by a clear gap. Define SHIFT_REG_CTRL_PARITY_EN to append an even-parity bit.
module shift_reg_ctrl
  import shift_reg_ctrl_pkg::*;
#(
  parameter int SHIFT_WIDTH = DEFAULT_SHIFT_WIDTH,
  parameter int GAP_CYCLES  = DEFAULT_GAP_CYCLES
) (
  input  logic                   clock,
  input  logic                   aclr_n,
  shift_reg_ctrl_if.slave        bus,
  input  logic                   abort,
  output logic                   sr_load,
  output logic                   sr_enable,
  output logic                   sr_sclr,
  output logic                   sr_sset,
  output logic                   sr_shiftin,
  output logic [SHIFT_WIDTH-1:0] sr_data,
  input  logic                   sr_shiftout,
  output logic                   ser_out,
  output logic                   ser_valid,
  output logic                   frame_done,
  output logic                   busy
);

  localparam logic [3:0] GAP_LAST = 4'(GAP_CYCLES - 1);

  state_t                 state_reg;
  state_t                 state_next;
  logic [SHIFT_WIDTH-1:0] sr_data_reg;
  logic [3:0]             gap_cnt_reg;
  logic                   aborted_reg;
  logic                   bit_tc;
  logic                   transfer;
  logic                   gap_last;
  logic                   gap_entry;
`ifdef SHIFT_REG_CTRL_PARITY_EN
  logic                   parity_reg;
`endif

  assign bus.in_ready = (state_reg == IDLE) && !abort;
  assign transfer     = bus.in_valid && bus.in_ready;
  assign gap_last     = (gap_cnt_reg == GAP_LAST);
  assign gap_entry    = (state_reg != GAP) && (state_next == GAP);

  shift_bit_counter #(
    .COUNT_MAX (SHIFT_WIDTH)
  ) u_bit_counter (
    .clock  (clock),
    .aclr_n (aclr_n),
    .clear  (state_reg != SHIFT),
    .inc    (state_reg == SHIFT),
    .tc     (bit_tc)
  );

  // State register.
  always_ff @(posedge clock or negedge aclr_n) begin
    if (!aclr_n) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // Next-state logic: abort cuts any active frame short into the gap.
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:   if (transfer) state_next = LOAD;
      LOAD:   state_next = abort ? GAP : SHIFT;
      SHIFT: begin
        if (abort) begin
          state_next = GAP;
        end else if (bit_tc) begin
`ifdef SHIFT_REG_CTRL_PARITY_EN
          state_next = PARITY;
`else
          state_next = GAP;
`endif
        end
      end
`ifdef SHIFT_REG_CTRL_PARITY_EN
      PARITY: state_next = GAP;
`endif
      GAP:    if (gap_last) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Register-control and serial outputs decoded from the current state.
  always_comb begin
    sr_load   = 1'b0;
    sr_enable = 1'b0;
    sr_sclr   = 1'b0;
    ser_out   = 1'b0;
    ser_valid = 1'b0;
    case (state_reg)
      LOAD: begin
        sr_load   = 1'b1;
        sr_enable = 1'b1;
      end
      SHIFT: begin
        sr_enable = 1'b1;
        ser_out   = sr_shiftout;
        ser_valid = 1'b1;
      end
`ifdef SHIFT_REG_CTRL_PARITY_EN
      PARITY: begin
        ser_out   = parity_reg;
        ser_valid = 1'b1;
      end
`endif
      GAP: begin
        sr_sclr   = 1'b1;
        sr_enable = 1'b1;
      end
      default: ;
    endcase
  end

  // Word capture on the transfer edge only; held for the whole frame.
  always_ff @(posedge clock or negedge aclr_n) begin
    if (!aclr_n) begin
      sr_data_reg <= '0;
    end else if (transfer) begin
      sr_data_reg <= bus.in_data;
    end
  end

  // Gap length counter plus a flag remembering whether this gap follows an abort.
  always_ff @(posedge clock or negedge aclr_n) begin
    if (!aclr_n) begin
      gap_cnt_reg <= '0;
      aborted_reg <= 1'b0;
    end else begin
      gap_cnt_reg <= (state_reg == GAP) ? gap_cnt_reg + 4'd1 : 4'd0;
      if (gap_entry) begin
        aborted_reg <= abort;
      end
    end
  end

`ifdef SHIFT_REG_CTRL_PARITY_EN
  // Even parity over the bits actually sent during SHIFT.
  always_ff @(posedge clock or negedge aclr_n) begin
    if (!aclr_n) begin
      parity_reg <= 1'b0;
    end else if (state_reg == LOAD) begin
      parity_reg <= 1'b0;
    end else if (state_reg == SHIFT) begin
      parity_reg <= parity_reg ^ sr_shiftout;
    end
  end
`endif

  assign frame_done = (state_reg == GAP) && (gap_cnt_reg == 4'd0) && !aborted_reg;
  assign busy       = (state_reg != IDLE);
  assign sr_data    = sr_data_reg;
  assign sr_sset    = 1'b0;
  assign sr_shiftin = 1'b0;

endmodule

// File: tb/tb_shift_reg_ctrl.sv
// tb_shift_reg_ctrl: table-driven frames, hand-written corner sequences and a
// randomized run checked against a frame-timeline reference model.
// Honors SHIFT_REG_CTRL_PARITY_EN when the design is built with it.
module tb_shift_reg_ctrl;

  localparam int N   = 8;
  localparam int GAP = 1;
`ifdef SHIFT_REG_CTRL_PARITY_EN
  localparam int P = 1;
`else
  localparam int P = 0;
`endif

  logic         clock = 1'b0;
  logic         aclr_n;
  logic         abort;
  logic         sr_load, sr_enable, sr_sclr, sr_sset, sr_shiftin, sr_shiftout;
  logic [N-1:0] sr_data;
  logic         ser_out, ser_valid, frame_done, busy;
  logic [N-1:0] sreg;

  int n_cmp = 0;
  int n_err = 0;

  shift_reg_ctrl_if #(.SHIFT_WIDTH(N)) bus ();

  shift_reg_ctrl #(.SHIFT_WIDTH(N), .GAP_CYCLES(GAP)) dut (
    .clock       (clock),
    .aclr_n      (aclr_n),
    .bus         (bus),
    .abort       (abort),
    .sr_load     (sr_load),
    .sr_enable   (sr_enable),
    .sr_sclr     (sr_sclr),
    .sr_sset     (sr_sset),
    .sr_shiftin  (sr_shiftin),
    .sr_data     (sr_data),
    .sr_shiftout (sr_shiftout),
    .ser_out     (ser_out),
    .ser_valid   (ser_valid),
    .frame_done  (frame_done),
    .busy        (busy)
  );

  always #5 clock = ~clock;

  // The controlled left-shifting register (sclr over load over shift).
  always @(posedge clock or negedge aclr_n) begin
    if (!aclr_n) sreg <= '0;
    else if (sr_enable) begin
      if (sr_sclr)      sreg <= '0;
      else if (sr_load) sreg <= sr_data;
      else              sreg <= {sreg[N-2:0], sr_shiftin};
    end
  end
  assign sr_shiftout = sreg[N-1];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic wait_idle();
    int w;
    w = 0;
    while (!(bus.in_ready === 1'b1 && busy === 1'b0) && w < 100) begin
      @(negedge clock);
      w++;
    end
    chk("wait_idle", 32'(w < 100), 32'd1);
  endtask

  typedef struct {
    logic [7:0]  data;
    int          abort_at;
    int          exp_n;
    logic [31:0] exp_bits;
    int          exp_done;
    int          exp_lat;
    int          exp_didx;
  } vec_t;

  vec_t vecs[8];

  int          r_n, r_done, r_lat, r_didx, r_load_ok, r_abort_ok;
  logic [31:0] r_bits;

  // One frame: indices count edges after the transfer edge (0 = LOAD cycle).
  task automatic run_frame(input logic [7:0] d, input int abort_at);
    int shifts;
    int w;
    r_bits = '0; r_n = 0; r_done = 0; r_lat = -1; r_didx = -1;
    r_load_ok = 0; r_abort_ok = -1; shifts = 0; w = 0;
    while (bus.in_ready !== 1'b1 && w < 50) begin
      @(negedge clock);
      w++;
    end
    bus.in_valid = 1'b1;
    bus.in_data  = d;
    @(negedge clock);
    bus.in_valid = 1'b0;
    for (int idx = 0; idx < 40; idx++) begin
      if (idx > 0) @(negedge clock);
      if (idx == 0) r_load_ok = int'(sr_load && sr_enable && !ser_valid && sr_data == d);
      if (abort) begin
        r_abort_ok = int'(sr_sclr && sr_enable && !frame_done && !ser_valid && busy);
        abort = 1'b0;
      end
      if (ser_valid) begin
        r_bits = {r_bits[30:0], ser_out};
        r_n++;
      end
      if (frame_done) begin
        r_done++;
        r_didx = idx;
      end
      if (bus.in_ready && idx > 0) begin
        r_lat = idx;
        break;
      end
      if (ser_valid && sr_enable) begin
        shifts++;
        if (shifts == abort_at) abort = 1'b1;
      end
    end
    abort = 1'b0;
  endtask

  int          loads, phase, zrun, shifts;
  logic        first2;
  int          t_acc, ph, frames;
  logic [7:0]  mdata;
  logic        have_word, e_busy, e_valid, e_out, e_done, e_load;

  initial begin
    // Normal frames: N(+parity) bits, done one index after the last bit.
    vecs[0] = '{8'hA5, 0, N+P, (P == 1) ? 32'h14A : 32'hA5, 1, N+1+P+GAP, N+1+P};
    vecs[1] = '{8'h07, 0, N+P, (P == 1) ? 32'h00F : 32'h07, 1, N+1+P+GAP, N+1+P};
    vecs[2] = '{8'h3C, 5, 5,   32'h07,                      0, 5+1+GAP,   -1};
    vecs[3] = '{8'hFF, 0, N+P, (P == 1) ? 32'h1FE : 32'hFF, 1, N+1+P+GAP, N+1+P};
    vecs[4] = '{8'h80, 1, 1,   32'h01,                      0, 1+1+GAP,   -1};
    vecs[5] = '{8'h01, 8, 8,   32'h01,                      0, 8+1+GAP,   -1};
    vecs[6] = '{8'h5A, 0, N+P, (P == 1) ? 32'h0B4 : 32'h5A, 1, N+1+P+GAP, N+1+P};
    vecs[7] = '{8'h00, 0, N+P, 32'h00,                      1, N+1+P+GAP, N+1+P};

    aclr_n = 1'b0; abort = 1'b0; bus.in_valid = 1'b0; bus.in_data = '0;
    #12;
    chk("rst_in_ready", bus.in_ready, 1);
    chk("rst_busy", busy, 0);
    chk("rst_sr_data", sr_data, 0);
    chk("rst_ctrl", {sr_load, sr_enable, sr_sclr, sr_sset, sr_shiftin}, 0);
    chk("rst_serial", {ser_out, ser_valid, frame_done}, 0);
    abort = 1'b1; #1;
    chk("rst_in_ready_abort", bus.in_ready, 0);
    abort = 1'b0;
    @(negedge clock);
    aclr_n = 1'b1;
    @(negedge clock);

    for (int i = 0; i < 8; i++) begin
      run_frame(vecs[i].data, vecs[i].abort_at);
      $display("VEC %0d data=%h abort_at=%0d bits=%0d val=%0h done=%0d lat=%0d",
               i, vecs[i].data, vecs[i].abort_at, r_n, r_bits, r_done, r_lat);
      chk("vec_load", r_load_ok, 1);
      chk("vec_nbits", r_n, vecs[i].exp_n);
      chk("vec_bits", r_bits, vecs[i].exp_bits);
      chk("vec_done", r_done, vecs[i].exp_done);
      chk("vec_done_idx", r_didx, vecs[i].exp_didx);
      chk("vec_ready_lat", r_lat, vecs[i].exp_lat);
      if (vecs[i].abort_at > 0) chk("vec_abort_gap", r_abort_ok, 1);
    end

    // Back-to-back with in_valid held high: FF then 00.
    wait_idle();
    bus.in_valid = 1'b1; bus.in_data = 8'hFF;
    loads = 0; phase = 0; zrun = 0; first2 = 1'b1;
    for (int c = 0; c < 60 && phase < 3; c++) begin
      @(negedge clock);
      if (sr_load) begin
        loads++;
        if (loads == 1) bus.in_data = 8'h00;
        else bus.in_valid = 1'b0;
      end
      case (phase)
        0: if (ser_valid) phase = 1;
        1: if (!ser_valid) begin phase = 2; zrun = 1; end
        2: if (ser_valid) begin phase = 3; first2 = ser_out; end
           else zrun++;
        default: ;
      endcase
    end
    bus.in_valid = 1'b0;
    $display("B2B loads=%0d gap=%0d first=%0b", loads, zrun, first2);
    chk("b2b_gap", zrun, GAP+2);
    chk("b2b_loads", loads, 2);
    chk("b2b_first0", first2, 0);
    wait_idle();

    // Reset during the 4th SHIFT cycle, then immediate acceptance after release.
    bus.in_valid = 1'b1; bus.in_data = 8'h3C; shifts = 0;
    @(negedge clock);
    bus.in_valid = 1'b0;
    for (int c = 0; c < 20 && shifts < 4; c++) begin
      @(negedge clock);
      if (ser_valid && sr_enable) shifts++;
    end
    aclr_n = 1'b0;
    #1;
    $display("RST mid-frame after %0d shifts", shifts);
    chk("mrst_enable", sr_enable, 0);
    chk("mrst_valid", ser_valid, 0);
    chk("mrst_busy", busy, 0);
    chk("mrst_ready", bus.in_ready, 1);
    chk("mrst_sr_data", sr_data, 0);
    @(negedge clock);
    aclr_n = 1'b1; bus.in_valid = 1'b1; bus.in_data = 8'hA5;
    @(negedge clock);
    bus.in_valid = 1'b0;
    chk("post_rst_load", sr_load, 1);
    chk("post_rst_data", sr_data, 8'hA5);
    wait_idle();

    // Backpressure: second word offered while busy must wait.
    bus.in_valid = 1'b1; bus.in_data = 8'h11;
    @(negedge clock);
    bus.in_data = 8'h22;
    for (int c = 0; c < 3; c++) begin
      @(negedge clock);
      chk("bp_ready", bus.in_ready, 0);
      chk("bp_hold", sr_data, 8'h11);
    end
    for (int c = 0; c < 30 && bus.in_ready !== 1'b1; c++) @(negedge clock);
    @(negedge clock);
    bus.in_valid = 1'b0;
    $display("BP second word data=%h load=%0b", sr_data, sr_load);
    chk("bp_second_data", sr_data, 8'h22);
    chk("bp_second_load", sr_load, 1);
    wait_idle();

    // Abort in IDLE blocks acceptance and changes nothing else.
    abort = 1'b1; bus.in_valid = 1'b1; bus.in_data = 8'h99;
    #1;
    chk("idle_abort_ready", bus.in_ready, 0);
    @(negedge clock);
    chk("idle_abort_busy", busy, 0);
    chk("idle_abort_data", sr_data, 8'h22);
    abort = 1'b0; bus.in_valid = 1'b0;
    @(negedge clock);

    // Randomized traffic against a frame-timeline model.
    t_acc = -1000; have_word = 1'b0; frames = 0; mdata = '0;
    for (int c = 0; c < 900; c++) begin
      @(negedge clock);
      ph      = c - t_acc;
      e_busy  = (ph >= 1 && ph <= N+1+P+GAP);
      e_valid = (ph >= 2 && ph <= N+1+P);
      e_done  = (ph == N+2+P);
      e_load  = (ph == 1);
      e_out   = 1'b0;
      if (ph >= 2 && ph <= N+1) e_out = mdata[N-1-(ph-2)];
      else if (ph == N+2 && P == 1) e_out = ^mdata;
      chk("rnd_busy", busy, e_busy);
      chk("rnd_ready", bus.in_ready, !e_busy);
      chk("rnd_valid", ser_valid, e_valid);
      chk("rnd_done", frame_done, e_done);
      chk("rnd_load", sr_load, e_load);
      chk("rnd_sset_shiftin", {sr_sset, sr_shiftin}, 0);
      if (e_valid) chk("rnd_ser_out", ser_out, e_out);
      if (have_word) chk("rnd_sr_data", sr_data, mdata);
      bus.in_valid = ($urandom_range(2) == 0);
      bus.in_data  = 8'($urandom_range(255));
      if (bus.in_valid && !e_busy) begin
        t_acc = c; mdata = bus.in_data; have_word = 1'b1; frames++;
        $display("RND frame %0d data=%h at cycle %0d", frames, mdata, c);
      end
    end
    bus.in_valid = 1'b0;
    wait_idle();
    chk("rnd_frames_nonzero", 32'(frames > 10), 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/shift_reg_ctrl.md
SHIFT_REG_CTRL -- requirements
Module: shift_reg_ctrl

Interface
REQ-001 Parameter SHIFT_WIDTH, default 8: word width of the controlled shift register; legal values 2..32.
REQ-002 Parameter GAP_CYCLES, default 1: inter-frame clear cycles; legal values 1..15.
REQ-003 Port clock  input  1: single clock; all state updates on the rising edge.
REQ-004 Port aclr_n  input  1: asynchronous, active-low reset.
REQ-005 Port in_valid  input  1: a parallel word is offered.
REQ-006 Port in_ready  output  1: the controller accepts a word; transfer occurs on a rising edge with in_valid=1 and in_ready=1.
REQ-007 Port in_data  input  SHIFT_WIDTH: the parallel word to serialize, MSB first.
REQ-008 Port abort  input  1: synchronous frame abort.
REQ-009 Ports sr_load, sr_enable, sr_sclr, sr_sset, sr_shiftin  output  1 each: control pins of the left-shifting register.
REQ-010 Port sr_data  output  SHIFT_WIDTH: parallel load value for the register.
REQ-011 Port sr_shiftout  input  1: the register's serial output, which is its MSB.
REQ-012 Ports ser_out, ser_valid  output  1 each: the serial bit and its qualifier.
REQ-013 Ports frame_done, busy  output  1 each: one-cycle completion pulse; high in any non-IDLE state.

Function
REQ-014 The FSM SHALL have the states IDLE, LOAD, SHIFT, PARITY (macro only) and GAP.
REQ-015 in_ready SHALL equal (state==IDLE && !abort); on a transfer, in_data SHALL be captured into sr_data and the state SHALL become LOAD.
REQ-016 LOAD, one cycle: sr_load=1, sr_enable=1; the next state SHALL be SHIFT with the bit counter at 0.
REQ-017 SHIFT, SHIFT_WIDTH cycles: sr_enable=1, sr_load=0, sr_shiftin=0, ser_out=sr_shiftout, ser_valid=1; the counter SHALL increment each cycle; at count SHIFT_WIDTH-1 the state SHALL go to GAP (or PARITY).
REQ-018 GAP, GAP_CYCLES cycles: sr_sclr=1, sr_enable=1, ser_valid=0; frame_done=1 only in the first GAP cycle of a completed frame; then IDLE.
REQ-019 abort=1 in LOAD, SHIFT or PARITY SHALL force the next state to GAP with frame_done suppressed for that gap; abort in IDLE or GAP SHALL have no effect.
REQ-020 sr_sset SHALL be constant 0; sr_data SHALL hold its value outside a transfer edge.
REQ-021 A new word SHALL NOT be accepted before the controller returns to IDLE, so back-to-back frames are separated by GAP_CYCLES+2 cycles with ser_valid=0.
REQ-022 The counter width SHALL be $clog2(SHIFT_WIDTH) bits; wrap-around past SHIFT_WIDTH-1 SHALL NOT occur.

Reset
REQ-023 With aclr_n=0, the controller SHALL immediately enter IDLE, set the counter and sr_data to 0, and drive all outputs to 0 except in_ready=1 (when abort=0), regardless of any frame in progress.
REQ-024 After aclr_n is released, the first transfer SHALL be accepted on the first rising edge with in_valid=1.

Configuration
REQ-025 With SHIFT_REG_CTRL_PARITY_EN defined, the controller SHALL go from SHIFT to PARITY for one cycle: sr_enable=0, ser_valid=1, ser_out = XOR of all transmitted data bits (even parity); it SHALL then go to GAP.
REQ-026 Without SHIFT_REG_CTRL_PARITY_EN, the PARITY state and the parity accumulator SHALL be absent, and the frame SHALL be SHIFT_WIDTH bits.

Structure
REQ-027 The package shift_reg_ctrl_pkg SHALL hold the state enum typedef, the state encodings and the default SHIFT_WIDTH and GAP_CYCLES constants.
REQ-028 One sub-module, shift_bit_counter, SHALL implement the bit counter with clear, increment and terminal-count output.

Verification
REQ-029 Single frame (SHIFT_WIDTH=8, GAP_CYCLES=1), in_data=8'hA5: LOAD one cycle after the transfer, then ser_out=1,0,1,0,0,1,0,1 with ser_valid=1; frame_done on the next cycle with sr_sclr=1; in_ready=1 ten cycles after the transfer edge.
REQ-030 Back-to-back, in_valid held high with 8'hFF then 8'h00: the second word is accepted in the first IDLE cycle; exactly 3 ser_valid=0 cycles separate the last 1 and the first 0.
REQ-031 Abort during 8'h3C with abort=1 at the 5th SHIFT cycle: the next cycle is GAP with sr_sclr=1 and frame_done=0, then IDLE.
REQ-032 Reset mid-frame, aclr_n low during the 4th SHIFT cycle: outputs are immediately sr_enable=0, ser_valid=0, busy=0, in_ready=1.
REQ-033 Backpressure, in_data changed 8'h11 -> 8'h22 while busy with in_valid=1: in_ready=0 and sr_data keeps the frame's word.
REQ-034 With SHIFT_REG_CTRL_PARITY_EN: 8'hA5 gives 9th bit 0; 8'h07 gives 9th bit 1; frame_done follows the 9th bit.
